// File: rtl/prbs_pkg.sv
// prbs_pkg: shared types and constants for the PRBS checker.
//   state_t      - checker FSM state encoding
//   COUNT_W      - width of the saturating statistics counters
//   lfsr_coeff() - Galois feedback mask (bit n-1 set for each tap n) for a
//                  given LFSR width, 3..64; returned in a 64-bit container.
package prbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_VERIFY  = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    localparam int COUNT_W = 32;

    // Single-bit mask for tap position n (taps are numbered from 1).
    function automatic logic [63:0] tap(input int n);
        return 64'd1 << (n - 1);
    endfunction

    // Maximal-length tap sets; the top tap always equals the width, so the
    // feedback bit lands in the MSB after the right shift.
    function automatic logic [63:0] lfsr_coeff(input int width);
        case (width)
            3:  return tap(3)  | tap(2);
            4:  return tap(4)  | tap(3);
            5:  return tap(5)  | tap(3);
            6:  return tap(6)  | tap(5);
            7:  return tap(7)  | tap(6);
            8:  return tap(8)  | tap(6)  | tap(5)  | tap(4);
            9:  return tap(9)  | tap(5);
            10: return tap(10) | tap(7);
            11: return tap(11) | tap(9);
            12: return tap(12) | tap(6)  | tap(4)  | tap(1);
            13: return tap(13) | tap(4)  | tap(3)  | tap(1);
            14: return tap(14) | tap(5)  | tap(3)  | tap(1);
            15: return tap(15) | tap(14);
            16: return tap(16) | tap(15) | tap(13) | tap(4);
            17: return tap(17) | tap(14);
            18: return tap(18) | tap(11);
            19: return tap(19) | tap(6)  | tap(2)  | tap(1);
            20: return tap(20) | tap(17);
            21: return tap(21) | tap(19);
            22: return tap(22) | tap(21);
            23: return tap(23) | tap(18);
            24: return tap(24) | tap(23) | tap(22) | tap(17);
            25: return tap(25) | tap(22);
            26: return tap(26) | tap(6)  | tap(2)  | tap(1);
            27: return tap(27) | tap(5)  | tap(2)  | tap(1);
            28: return tap(28) | tap(25);
            29: return tap(29) | tap(27);
            30: return tap(30) | tap(6)  | tap(4)  | tap(1);
            31: return tap(31) | tap(28);
            32: return tap(32) | tap(22) | tap(2)  | tap(1);
            33: return tap(33) | tap(20);
            34: return tap(34) | tap(27) | tap(2)  | tap(1);
            35: return tap(35) | tap(33);
            36: return tap(36) | tap(25);
            37: return tap(37) | tap(5)  | tap(4)  | tap(3) | tap(2) | tap(1);
            38: return tap(38) | tap(6)  | tap(5)  | tap(1);
            39: return tap(39) | tap(35);
            40: return tap(40) | tap(38) | tap(21) | tap(19);
            41: return tap(41) | tap(38);
            42: return tap(42) | tap(41) | tap(20) | tap(19);
            43: return tap(43) | tap(42) | tap(38) | tap(37);
            44: return tap(44) | tap(43) | tap(18) | tap(17);
            45: return tap(45) | tap(44) | tap(42) | tap(41);
            46: return tap(46) | tap(45) | tap(26) | tap(25);
            47: return tap(47) | tap(42);
            48: return tap(48) | tap(47) | tap(21) | tap(20);
            49: return tap(49) | tap(40);
            50: return tap(50) | tap(49) | tap(24) | tap(23);
            51: return tap(51) | tap(50) | tap(36) | tap(35);
            52: return tap(52) | tap(49);
            53: return tap(53) | tap(52) | tap(38) | tap(37);
            54: return tap(54) | tap(53) | tap(18) | tap(17);
            55: return tap(55) | tap(31);
            56: return tap(56) | tap(55) | tap(35) | tap(34);
            57: return tap(57) | tap(50);
            58: return tap(58) | tap(39);
            59: return tap(59) | tap(58) | tap(38) | tap(37);
            60: return tap(60) | tap(59);
            61: return tap(61) | tap(60) | tap(46) | tap(45);
            62: return tap(62) | tap(61) | tap(6)  | tap(5);
            63: return tap(63) | tap(62);
            64: return tap(64) | tap(63) | tap(61) | tap(60);
            default: return 64'd0;
        endcase
    endfunction

endpackage

// File: rtl/prbs_checker_lfsr.sv
// prbs_checker_lfsr: purely combinational single step of a right-shifting
// Galois LFSR:  dout = din[0] ? (din >> 1) ^ COEFF : din >> 1.
//   din  [WIDTH-1:0] - current LFSR state
//   dout [WIDTH-1:0] - next LFSR state
module prbs_checker_lfsr
    import prbs_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam logic [63:0]      COEFF_FULL = lfsr_coeff(WIDTH);
    localparam logic [WIDTH-1:0] COEFF      = COEFF_FULL[WIDTH-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign dout[gi] = din[gi + 1] ^ (din[0] & COEFF[gi]);
        end
    endgenerate

    // Nothing shifts into the MSB; it only ever receives feedback.
    assign dout[WIDTH-1] = din[0] & COEFF[WIDTH-1];

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: locks onto a Galois-LFSR word stream and counts errors.
//   clk        - sole clock, rising edge
//   reset      - synchronous active-high reset
//   enable     - run; low sends the FSM back to IDLE
//   clear      - synchronously zeroes err_count and word_count
//   din_valid  - qualifies din (no backpressure)
//   din        - received word, one LFSR state per valid word
//   locked     - high while in LOCKED
//   err_pulse  - one-cycle pulse per mismatched word while LOCKED
//   err_count  - saturating mismatch count
//   word_count - saturating count of valid words checked while LOCKED
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear,
    input  logic               din_valid,
    input  logic [WIDTH-1:0]   din,
    output logic               locked,
    output logic               err_pulse,
    output logic [COUNT_W-1:0] err_count,
    output logic [COUNT_W-1:0] word_count
);

    localparam logic [7:0]         LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [7:0]         LOSS_LAST = 8'(LOSS_COUNT - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   expected_reg, expected_next;
    logic [7:0]         match_cnt_reg, match_cnt_next;
    logic [7:0]         miss_cnt_reg, miss_cnt_next;
    logic               locked_reg;
    logic               err_pulse_reg;
    logic [COUNT_W-1:0] err_count_reg;
    logic [COUNT_W-1:0] word_count_reg;

    logic [WIDTH-1:0]   lfsr_in;
    logic [WIDTH-1:0]   lfsr_out;
    logic               din_zero;
    logic               din_match;
    logic               err_hit;
    logic               word_hit;

    // Seeding and verifying step from the received word; once locked the
    // checker flywheels on its own expectation. A VERIFY match has
    // din == expected, so stepping din there is the same as stepping expected.
    assign lfsr_in   = (state_reg == ST_LOCKED) ? expected_reg : din;
    assign din_zero  = (din == '0);
    assign din_match = (din == expected_reg);

    prbs_checker_lfsr #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .din  (lfsr_in),
        .dout (lfsr_out)
    );

    always_comb begin
        state_next     = state_reg;
        expected_next  = expected_reg;
        match_cnt_next = match_cnt_reg;
        miss_cnt_next  = miss_cnt_reg;
        err_hit        = 1'b0;
        word_hit       = 1'b0;

        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    // All-zero is the LFSR lockup word and can never seed.
                    if (din_valid && !din_zero) begin
                        expected_next  = lfsr_out;
                        match_cnt_next = 8'd0;
                        state_next     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (din_valid) begin
                        if (din_match) begin
                            expected_next  = lfsr_out;
                            match_cnt_next = match_cnt_reg + 8'd1;
                            if (match_cnt_reg == LOCK_LAST) begin
                                miss_cnt_next = 8'd0;
                                state_next    = ST_LOCKED;
                            end
                        end else if (!din_zero) begin
                            expected_next  = lfsr_out;
                            match_cnt_next = 8'd0;
                        end else begin
                            state_next = ST_ACQUIRE;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (din_valid) begin
                        expected_next = lfsr_out;
                        word_hit      = 1'b1;
                        if (din_match) begin
                            miss_cnt_next = 8'd0;
                        end else begin
                            err_hit       = 1'b1;
                            miss_cnt_next = miss_cnt_reg + 8'd1;
                            if (miss_cnt_reg == LOSS_LAST) begin
                                state_next = ST_ACQUIRE;
                            end
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            expected_reg   <= '0;
            match_cnt_reg  <= 8'd0;
            miss_cnt_reg   <= 8'd0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
            err_count_reg  <= '0;
            word_count_reg <= '0;
        end else begin
            state_reg     <= state_next;
            expected_reg  <= expected_next;
            match_cnt_reg <= match_cnt_next;
            miss_cnt_reg  <= miss_cnt_next;
            locked_reg    <= (state_next == ST_LOCKED);
            err_pulse_reg <= err_hit;

            // clear beats a coincident increment; both counters saturate.
            if (clear) begin
                err_count_reg <= '0;
            end else if (err_hit && (err_count_reg != CNT_MAX)) begin
                err_count_reg <= err_count_reg + 1'b1;
            end

            if (clear) begin
                word_count_reg <= '0;
            end else if (word_hit && (word_count_reg != CNT_MAX)) begin
                word_count_reg <= word_count_reg + 1'b1;
            end
        end
    end

    assign locked     = locked_reg;
    assign err_pulse  = err_pulse_reg;
    assign err_count  = err_count_reg;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed self-checking bench for prbs_checker (WIDTH=16,
// LOCK_COUNT=4, LOSS_COUNT=3). Inputs change 1 time unit after the rising
// edge, outputs are checked at that same point.
module tb_prbs_checker;
    import prbs_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        din_valid = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_count;
    logic [31:0] word_count;

    int          tests = 0;
    int          failed = 0;
    logic [15:0] exp_word;

    always #5 clk = ~clk;

    prbs_checker #(
        .WIDTH      (16),
        .LOCK_COUNT (4),
        .LOSS_COUNT (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .clear      (clear),
        .din_valid  (din_valid),
        .din        (din),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .word_count (word_count)
    );

    // Independent reference step for the 16-bit stream (taps 16,15,13,4).
    function automatic logic [15:0] tb_next(input logic [15:0] x);
        return x[0] ? ((x >> 1) ^ 16'hD008) : (x >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        $display("[TB] check %-22s observed %h expected %h", tag, obs, expv);
    endtask

    task automatic send(input logic v, input logic [15:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic send_lock_seq();
        send(1'b1, 16'h0001);
        send(1'b1, 16'hD008);
        send(1'b1, 16'h6804);
        send(1'b1, 16'h3402);
        check("not_locked_early", 32'(locked), 32'd0);
        send(1'b1, 16'h1A01);
        check("locked_after_1a01", 32'(locked), 32'd1);
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_count", err_count, 32'd0);
        check("rst_word_count", word_count, 32'd0);
        check("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));

        reset  = 1'b0;
        enable = 1'b1;
        send(1'b0, 16'h0000);
        check("idle_to_acquire", 32'(dut.state_reg), 32'(ST_ACQUIRE));

        // Scenario 1: lock on 0001, D008, 6804, 3402, 1A01
        send_lock_seq();
        check("s1_err_count", err_count, 32'd0);
        check("s1_word_count", word_count, 32'd0);

        // Scenario 2: single error then recovery match
        send(1'b1, 16'hDD09);
        check("s2_err_pulse", 32'(err_pulse), 32'd1);
        check("s2_err_count", err_count, 32'd1);
        check("s2_locked", 32'(locked), 32'd1);
        send(1'b1, 16'h6E84);
        check("s2_pulse_one_cycle", 32'(err_pulse), 32'd0);
        check("s2_err_count_hold", err_count, 32'd1);
        check("s2_word_count", word_count, 32'd2);

        // Scenario 3: three consecutive errors lose lock (expected 3742,1BA1,DDD8)
        send(1'b1, 16'hFFFF);
        send(1'b1, 16'hFFFF);
        check("s3_still_locked", 32'(locked), 32'd1);
        send(1'b1, 16'hFFFF);
        check("s3_err_count", err_count, 32'd4);
        check("s3_locked_fall", 32'(locked), 32'd0);
        check("s3_state", 32'(dut.state_reg), 32'(ST_ACQUIRE));
        check("s3_word_count", word_count, 32'd5);

        // Scenario 4: lockup word rejected in ACQUIRE
        for (int i = 0; i < 10; i++) send(1'b1, 16'h0000);
        check("s4_state", 32'(dut.state_reg), 32'(ST_ACQUIRE));
        check("s4_locked", 32'(locked), 32'd0);
        check("s4_word_count", word_count, 32'd5);

        // Relock, then Scenario 5: clear coincident with a mismatch
        send_lock_seq();
        clear = 1'b1;
        send(1'b1, 16'hDD09);
        clear = 1'b0;
        check("s5_err_count_cleared", err_count, 32'd0);
        check("s5_err_pulse", 32'(err_pulse), 32'd1);
        check("s5_word_count_cleared", word_count, 32'd0);

        // Alternate error/match five times: stays locked, err_count reaches 5
        exp_word = 16'h6E84;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, exp_word ^ 16'h0001);
            exp_word = tb_next(exp_word);
            send(1'b1, exp_word);
            exp_word = tb_next(exp_word);
        end
        check("alt_err_count", err_count, 32'd5);
        check("alt_locked", 32'(locked), 32'd1);
        check("alt_word_count", word_count, 32'd10);

        // Scenario 6: one-cycle reset mid-LOCKED
        reset = 1'b1;
        send(1'b1, exp_word ^ 16'h0001);
        reset = 1'b0;
        check("s6_locked", 32'(locked), 32'd0);
        check("s6_err_pulse", 32'(err_pulse), 32'd0);
        check("s6_err_count", err_count, 32'd0);
        check("s6_word_count", word_count, 32'd0);
        check("s6_state", 32'(dut.state_reg), 32'(ST_IDLE));

        // Reacquire from scratch after reset
        send(1'b0, 16'h0000);
        check("reacq_state", 32'(dut.state_reg), 32'(ST_ACQUIRE));
        send_lock_seq();

        // enable=0 with a mismatching word: no pulse, lock drops, counters hold
        enable = 1'b0;
        send(1'b1, 16'h1234);
        check("dis_err_pulse", 32'(err_pulse), 32'd0);
        check("dis_locked", 32'(locked), 32'd0);
        check("dis_state", 32'(dut.state_reg), 32'(ST_IDLE));
        check("dis_err_count", err_count, 32'd0);
        check("dis_word_count", word_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
